imem_loader_ctrl: RTL and testbench

Byte-stream boot loader controller that programs instruction memory through its byte-wide loader write port (write_addr, write_data, write_en).
- Parses framed bytes from the UART receiver (valid/ready stream).
- Range-checks the target region and issues one memory byte write per payload byte.
- Verifies a checksum.
- Holds the CPU stalled while a load is in progress.
- Publishes the frame's start address as the boot PC on success.

---
 rtl/imem_loader_ctrl.sv | 169 ++++++++++++++++
 tb/tb_imem_loader_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader_ctrl.sv
// imem_loader_ctrl
//   Boot loader that turns a framed UART byte stream into byte writes on the
//   instruction-memory loader port.
//   Frame: SYNC, ADDR[4 LE], LEN[4 LE], LEN payload bytes, CSUM (sum mod 256).
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   rx_data/rx_valid        received byte stream (source side)
//   rx_ready                always 1 once out of reset (no backpressure)
//   mem_loader_write_*      one-cycle byte write strobe with address and data
//   cpu_stall               holds the CPU while a load is in flight or failed
//   boot_pc                 start address of the last good frame
//   load_done               one-cycle pulse on a good frame
//   load_error              sticky, cleared when the next frame's sync arrives
//
// Handshake: a byte transfers on a rising clk edge where rx_valid && rx_ready;
// rx_data is only looked at on such an edge, and rx_ready never drops after
// reset, so the source may present a new byte every cycle.
module imem_loader_ctrl #(
  parameter int unsigned MEMORY_SIZE    = 8196,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [31:0] mem_loader_write_addr,
  output logic [7:0]  mem_loader_write_data,
  output logic        mem_loader_write_en,
  output logic        cpu_stall,
  output logic [31:0] boot_pc,
  output logic        load_done,
  output logic        load_error
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [32:0]   MEM_LIMIT = 33'(MEMORY_SIZE);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_LEN   = 3'd2,
    S_DATA  = 3'd3,
    S_CSUM  = 3'd4,
    S_DRAIN = 3'd5
  } state_t;

  state_t        state;
  logic [31:0]   addr_reg;
  logic [31:0]   len_reg;
  logic [31:0]   idx;
  logic [1:0]    byte_cnt;
  logic [7:0]    csum;
  logic [TW-1:0] idle_cnt;

  logic          xfer;
  logic [31:0]   len_full;
  logic [32:0]   end_addr;

  assign xfer = rx_valid & rx_ready;

  // Fields arrive little-endian, so each byte is shifted in from the top.
  // On the 4th LEN byte the complete length is this shifted value, which
  // lets the range check happen on the same edge the byte is accepted.
  always_comb begin
    len_full = {rx_data, len_reg[31:8]};
    end_addr = {1'b0, addr_reg} + {1'b0, len_full};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                 <= S_IDLE;
      addr_reg              <= '0;
      len_reg               <= '0;
      idx                   <= '0;
      byte_cnt              <= '0;
      csum                  <= '0;
      idle_cnt              <= '0;
      rx_ready              <= 1'b0;
      mem_loader_write_addr <= '0;
      mem_loader_write_data <= '0;
      mem_loader_write_en   <= 1'b0;
      cpu_stall             <= 1'b0;
      boot_pc               <= '0;
      load_done             <= 1'b0;
      load_error            <= 1'b0;
    end else begin
      rx_ready            <= 1'b1;
      mem_loader_write_en <= 1'b0;
      load_done           <= 1'b0;

      // Inter-byte watchdog. It only fires on a cycle with no transfer, so it
      // never competes with the byte handling in the case below.
      if (state != S_IDLE) begin
        if (xfer) begin
          idle_cnt <= '0;
        end else if (idle_cnt == TO_LAST) begin
          idle_cnt   <= '0;
          load_error <= 1'b1;
          state      <= S_IDLE;
        end else begin
          idle_cnt <= idle_cnt + TW'(1);
        end
      end

      if (xfer) begin
        case (state)
          S_IDLE: begin
            if (rx_data == SYNC_BYTE) begin
              state      <= S_ADDR;
              cpu_stall  <= 1'b1;
              load_error <= 1'b0;
              byte_cnt   <= '0;
              idx        <= '0;
              csum       <= '0;
              idle_cnt   <= '0;
            end
          end
          S_ADDR: begin
            addr_reg <= {rx_data, addr_reg[31:8]};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) state <= S_LEN;
          end
          S_LEN: begin
            len_reg  <= len_full;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              if (end_addr > MEM_LIMIT) state <= S_DRAIN;
              else if (len_full == 32'd0) state <= S_CSUM;
              else state <= S_DATA;
            end
          end
          S_DATA: begin
            mem_loader_write_en   <= 1'b1;
            mem_loader_write_addr <= addr_reg + idx;
            mem_loader_write_data <= rx_data;
            csum                  <= csum + rx_data;
            idx                   <= idx + 32'd1;
            if (idx == len_reg - 32'd1) state <= S_CSUM;
          end
          S_CSUM: begin
            if (rx_data == csum) begin
              load_done <= 1'b1;
              boot_pc   <= addr_reg;
              cpu_stall <= 1'b0;
            end else begin
              load_error <= 1'b1;
            end
            state <= S_IDLE;
          end
          S_DRAIN: begin
            // idx runs 0..len_reg: LEN payload bytes plus the checksum byte,
            // without needing a 33-bit LEN+1 count.
            idx <= idx + 32'd1;
            if (idx == len_reg) begin
              load_error <= 1'b1;
              state      <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader_ctrl.sv
module tb_imem_loader_ctrl;

  localparam int unsigned MEM_SIZE = 8196;
  localparam int unsigned TIMEOUT  = 16;
  localparam logic [7:0]  SYNC     = 8'hA5;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [31:0] mem_loader_write_addr;
  logic [7:0]  mem_loader_write_data;
  logic        mem_loader_write_en;
  logic        cpu_stall;
  logic [31:0] boot_pc;
  logic        load_done;
  logic        load_error;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  imem_loader_ctrl #(
    .MEMORY_SIZE   (MEM_SIZE),
    .TIMEOUT_CYCLES(TIMEOUT),
    .SYNC_BYTE     (SYNC)
  ) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .rx_data              (rx_data),
    .rx_valid             (rx_valid),
    .rx_ready             (rx_ready),
    .mem_loader_write_addr(mem_loader_write_addr),
    .mem_loader_write_data(mem_loader_write_data),
    .mem_loader_write_en  (mem_loader_write_en),
    .cpu_stall            (cpu_stall),
    .boot_pc              (boot_pc),
    .load_done            (load_done),
    .load_error           (load_error)
  );

  // ---------------- scoreboard ----------------
  // write entry: {cycle, addr, data}; done entry: {cycle, boot_pc}
  logic [71:0] exp_q[$];
  logic [63:0] done_q[$];
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: pops an expectation whenever the DUT presents a write or done
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_loader_write_en) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", {32'(cyc), mem_loader_write_addr, mem_loader_write_data}, 72'd0);
        end else begin
          check("write", {32'(cyc), mem_loader_write_addr, mem_loader_write_data}, exp_q.pop_front());
        end
      end
      if (load_done) begin
        check("done_with_error", 72'(load_error), 72'd0);
        if (done_q.size() == 0) begin
          check("unexpected_done", {8'd0, 32'(cyc), boot_pc}, 72'd0);
        end else begin
          check("done", {8'd0, 32'(cyc), boot_pc}, {8'd0, done_q.pop_front()});
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  logic [7:0] pl[8];
  logic       stall_after_sync;
  logic       err_after_sync;

  // Called at a negedge; the byte is accepted on the next posedge, and its
  // write (if any) is visible in the cycle after that edge.
  task automatic send_byte(input logic [7:0] b, input bit wr, input logic [31:0] wa);
    rx_data  = b;
    rx_valid = 1'b1;
    if (wr) exp_q.push_back({32'(cyc + 1), wa, b});
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [31:0] a, input logic [31:0] n,
                            input logic [7:0] p[8], input int npl,
                            input bit send_cs, input logic [7:0] cs,
                            input bit wr, input bit ok);
    send_byte(SYNC, 1'b0, 32'd0);
    stall_after_sync = cpu_stall;
    err_after_sync   = load_error;
    for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8], 1'b0, 32'd0);
    for (int i = 0; i < 4; i++) send_byte(n[8*i +: 8], 1'b0, 32'd0);
    for (int i = 0; i < npl; i++) send_byte(p[i], wr, a + 32'(i));
    if (send_cs) begin
      if (ok) done_q.push_back({32'(cyc + 1), a});
      send_byte(cs, 1'b0, 32'd0);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // reset state
    repeat (3) @(negedge clk);
    check("rst_ready", 72'(rx_ready), 72'd0);
    check("rst_outputs", {32'(boot_pc), 8'(mem_loader_write_en), 8'(cpu_stall), 8'(load_done), 8'(load_error)}, 72'd0);
    rst_n = 1'b1;
    #1 check("ready_before_edge", 72'(rx_ready), 72'd0);
    @(negedge clk);
    check("ready_after_edge", 72'(rx_ready), 72'd1);

    // garbage then good frame at 0x100
    send_byte(8'h00, 1'b0, 32'd0);
    send_byte(8'hFF, 1'b0, 32'd0);
    check("garbage_no_stall", 72'(cpu_stall), 72'd0);
    pl = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_frame(32'h100, 32'd4, pl, 4, 1'b1, 8'h13, 1'b1, 1'b1);
    check("a_stall_during", 72'(stall_after_sync), 72'd1);
    idle(2);
    check("a_stall_after", 72'(cpu_stall), 72'd0);
    check("a_boot_pc", 72'(boot_pc), 72'h100);
    check("a_error", 72'(load_error), 72'd0);

    // same frame, bad checksum
    send_frame(32'h100, 32'd4, pl, 4, 1'b1, 8'h14, 1'b1, 1'b0);
    idle(2);
    check("bad_cs_error", 72'(load_error), 72'd1);
    check("bad_cs_stall", 72'(cpu_stall), 72'd1);
    check("bad_cs_boot_pc", 72'(boot_pc), 72'h100);

    // out of range: 0x2000 + 8 = 8200 > 8196, drain 8 payload + 1 csum
    pl = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
    send_frame(32'h2000, 32'd8, pl, 8, 1'b0, 8'h00, 1'b0, 1'b0);
    check("drain_err_cleared", 72'(err_after_sync), 72'd0);
    check("drain_err_before_cs", 72'(load_error), 72'd0);
    send_byte(8'h1C, 1'b0, 32'd0);
    check("drain_err_after_cs", 72'(load_error), 72'd1);
    check("drain_stall", 72'(cpu_stall), 72'd1);
    idle(1);

    // boundary: 0x2000 + 4 == 8196 is in range; A5 in payload is plain data
    pl = '{8'h01, 8'hA5, 8'h03, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00};
    send_frame(32'h2000, 32'd4, pl, 4, 1'b1, 8'hAD, 1'b1, 1'b1);
    check("edge_err_cleared", 72'(err_after_sync), 72'd0);
    idle(2);
    check("edge_boot_pc", 72'(boot_pc), 72'h2000);
    check("edge_error", 72'(load_error), 72'd0);

    // zero-length frame
    send_frame(32'h40, 32'd0, pl, 0, 1'b1, 8'h00, 1'b0, 1'b1);
    idle(2);
    check("len0_boot_pc", 72'(boot_pc), 72'h40);
    check("len0_stall", 72'(cpu_stall), 72'd0);

    // timeout after 2 of 4 payload bytes
    pl = '{8'hAA, 8'hBB, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_frame(32'h10, 32'd4, pl, 2, 1'b0, 8'h00, 1'b1, 1'b0);
    idle(TIMEOUT - 1);
    check("timeout_not_yet", 72'(load_error), 72'd0);
    idle(1);
    check("timeout_error", 72'(load_error), 72'd1);
    check("timeout_stall", 72'(cpu_stall), 72'd1);
    pl = '{8'h55, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_frame(32'h200, 32'd1, pl, 1, 1'b1, 8'h55, 1'b1, 1'b1);
    idle(2);
    check("post_timeout_boot_pc", 72'(boot_pc), 72'h200);
    check("post_timeout_error", 72'(load_error), 72'd0);

    // reset in the middle of DATA
    pl = '{8'h11, 8'h22, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_frame(32'h300, 32'd4, pl, 2, 1'b0, 8'h00, 1'b1, 1'b0);
    idle(2);
    check("mid_stall", 72'(cpu_stall), 72'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_outputs", {32'(boot_pc), 8'(mem_loader_write_en), 8'(cpu_stall), 8'(load_done), 8'(load_error)}, 72'd0);
    check("async_rst_ready", 72'(rx_ready), 72'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_byte(8'h33, 1'b0, 32'd0);
    send_byte(8'h44, 1'b0, 32'd0);
    send_byte(8'h77, 1'b0, 32'd0);
    idle(3);
    check("post_rst_stall", 72'(cpu_stall), 72'd0);
    check("post_rst_boot_pc", 72'(boot_pc), 72'd0);

    check("writes_left", 72'(exp_q.size()), 72'd0);
    check("dones_left", 72'(done_q.size()), 72'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
